cla32_rr_sched: RTL and testbench

- Shares one 32-bit carry-lookahead adder (`modified_cla32`) among NUM_REQ requesters.
- Uses round-robin arbitration, registered operands and a valid/ready response channel.
- Sits between client blocks (ALU lanes, address generators) and the single adder instance. Saves area versus per-client adders.
- Fixed 3-state sequencer: ACCEPT, compute, hold response.

---
 rtl/cla32_sched_pkg.sv | 22 ++
 rtl/cla32_rr_sched_rr_arbiter.sv | 30 +++
 rtl/modified_cla32.sv | 36 +++
 rtl/cla32_rr_sched.sv | 147 ++++++++++++++
 tb/tb_cla32_rr_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cla32_sched_pkg.sv
// Shared types and constants for the round-robin shared-adder scheduler.
package cla32_sched_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Ceiling log2, used to validate the requester index width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla32_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    logic [ID_W-1:0] idx;

    // Rotating priority search; index arithmetic wraps since NUM_REQ is a power of two.
    always_comb begin
        any      = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = idx;
            end
        end
        grant = NUM_REQ'(any) << grant_id;
    end

endmodule

// File: rtl/modified_cla32.sv
// 32-bit adder built from 4-bit carry-lookahead groups with group carries chained.
module modified_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    // Generate/propagate, per-group lookahead carries, then sum.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
        s  = p ^ c[31:0];
        co = c[32];
    end

endmodule

// File: rtl/cla32_rr_sched.sv
// Round-robin scheduler sharing one 32-bit CLA among NUM_REQ requesters.
// Optional subtract support when CLA32_SCHED_SUB_EN is defined (adds req_sub, rsp_ovf).
module cla32_rr_sched
    import cla32_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_ci,
`ifdef CLA32_SCHED_SUB_EN
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic                      rsp_ovf,
`endif
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_s,
    output logic                      rsp_co,
    output logic                      busy
);

    if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr;
    logic [DATA_W-1:0]   op_a, op_b;
    logic                op_ci;
    logic [ID_W-1:0]     op_id;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_id;
    logic                arb_any;
    logic                load_c;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic                sel_ci;
    logic [DATA_W-1:0]   sum;
    logic                sum_co;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    // Winner's operands; subtraction folds into inverted b and forced carry-in.
    always_comb begin
        sel_a  = req_a[arb_id*DATA_W +: DATA_W];
        sel_b  = req_b[arb_id*DATA_W +: DATA_W];
        sel_ci = req_ci[arb_id];
`ifdef CLA32_SCHED_SUB_EN
        if (req_sub[arb_id]) begin
            sel_b  = ~sel_b;
            sel_ci = 1'b1;
        end
`endif
    end

    // Next state and the combinational grant shown only while idle.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        load_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    load_c    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            if (load_c) rr_ptr <= arb_id + ID_W'(1);
        end
    end

    // Operand registers, captured only on the grant edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a  <= '0;
            op_b  <= '0;
            op_ci <= 1'b0;
            op_id <= '0;
        end else if (load_c) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_ci <= sel_ci;
            op_id <= arb_id;
        end
    end

    modified_cla32 u_cla (
        .a  (op_a),
        .b  (op_b),
        .ci (op_ci),
        .s  (sum),
        .co (sum_co)
    );

    // Response registers: loaded in CALC, held through RESP until accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_s     <= '0;
            rsp_co    <= 1'b0;
`ifdef CLA32_SCHED_SUB_EN
            rsp_ovf   <= 1'b0;
`endif
        end else if (state_q == CALC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_s     <= sum;
            rsp_co    <= sum_co;
`ifdef CLA32_SCHED_SUB_EN
            rsp_ovf   <= (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                         (sum[DATA_W-1] != op_a[DATA_W-1]);
`endif
        end else if (state_q == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cla32_rr_sched.sv
// Directed bench for cla32_rr_sched; define CLA32_SCHED_SUB_EN to cover subtraction.
module tb_cla32_rr_sched;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [32*NUM_REQ-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]   req_ci;
`ifdef CLA32_SCHED_SUB_EN
    logic [NUM_REQ-1:0]   req_sub;
    logic                 rsp_ovf;
`endif
    logic                 rsp_valid, rsp_ready, rsp_co, busy;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_s;

    int checks = 0;
    int passes = 0;

    cla32_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
`ifdef CLA32_SCHED_SUB_EN
        .req_sub   (req_sub),
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic ci);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_ci[i]         = ci;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_s"},     rsp_s,          32'd0);
        chk({tag, "_co"},    32'(rsp_co),    32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
`ifdef CLA32_SCHED_SUB_EN
        chk({tag, "_ovf"},   32'(rsp_ovf),   32'd0);
`endif
    endtask

    initial begin
        logic [31:0] exp_s [5];
        exp_s[0] = 32'd1;  exp_s[1] = 32'd12; exp_s[2] = 32'd23;
        exp_s[3] = 32'd34; exp_s[4] = 32'd1;

        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        rsp_ready = 1'b0;
`ifdef CLA32_SCHED_SUB_EN
        req_sub   = '0;
`endif

        // Reset state
        @(negedge clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;

        // Single request 0: FFFFFFFF + 1
        @(negedge clk);
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 4'b0100;
        set_op(2, 32'h1234_5678, 32'h1111_1111, 1'b1);
        #1;
        chk("t1_calc_ready", 32'(req_ready), 32'd0);
        chk("t1_calc_busy", 32'(busy), 32'd1);
        chk("t1_calc_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_s", rsp_s, 32'd0);
        chk("t1_co", 32'(rsp_co), 32'd1);
        chk("t1_id", 32'(rsp_id), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);

        // Backpressure: response held while rsp_ready=0
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_s", rsp_s, 32'd0);
            chk("bp_co", 32'(rsp_co), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
        chk("bp_rel_busy", 32'(busy), 32'd0);
        chk("bp_rel_ready", 32'(req_ready), 32'b0100);
        chk("bp_rel_s_hold", rsp_s, 32'd0);
        chk("bp_rel_co_hold", 32'(rsp_co), 32'd1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("bp_r2_s", rsp_s, 32'h2345_678A);
        chk("bp_r2_id", 32'(rsp_id), 32'd2);
        chk("bp_r2_co", 32'(rsp_co), 32'd0);

        // Reset in idle, then all four requesting continuously
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_idle_s", rsp_s, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i), 32'(10 * i), 1'b1);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'd1 << (k % 4));
            @(negedge clk);
            @(negedge clk);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_s", rsp_s, exp_s[k]);
            @(negedge clk);
        end

        // Grant to 1 moves pointer to 2; then 3 and 1 both request
        req_valid = 4'b0010;
        #1;
        chk("p2_ready1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("p2_s1", rsp_s, 32'd12);
        chk("p2_id1", 32'(rsp_id), 32'd1);
        @(negedge clk);
        chk("p2_ready3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("p2_id3", 32'(rsp_id), 32'd3);
        chk("p2_s3", rsp_s, 32'd34);
        @(negedge clk);
        chk("p2_ready1b", 32'(req_ready), 32'b0010);

        // Reset pulsed during CALC
        @(negedge clk);
        req_valid = '0;
        chk("ab_calc_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ab_no_rsp", 32'(rsp_valid), 32'd0);
        chk("ab_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("ab_no_rsp2", 32'(rsp_valid), 32'd0);
        req_valid = 4'b0101;
        #1;
        chk("ab_ptr0", 32'(req_ready), 32'b0001);
        req_valid = 4'b0100;
        #1;
        chk("ab_ready2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("ab_id2", 32'(rsp_id), 32'd2);
        chk("ab_s2", rsp_s, 32'd23);
        chk("ab_co2", 32'(rsp_co), 32'd0);

`ifdef CLA32_SCHED_SUB_EN
        // Subtraction with signed overflow, then a borrow
        @(negedge clk);
        set_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0);
        req_sub   = 4'b0001;
        req_valid = 4'b0001;
        #1;
        chk("sub1_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("sub1_s", rsp_s, 32'h7FFF_FFFF);
        chk("sub1_co", 32'(rsp_co), 32'd1);
        chk("sub1_ovf", 32'(rsp_ovf), 32'd1);
        @(negedge clk);
        set_op(0, 32'd5, 32'd7, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("sub2_s", rsp_s, 32'hFFFF_FFFE);
        chk("sub2_co", 32'(rsp_co), 32'd0);
        chk("sub2_ovf", 32'(rsp_ovf), 32'd0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
